inst_queue: RTL and testbench



---
 rtl/inst_queue_pkg.sv | 16 +
 rtl/inst_queue.sv | 113 +++++++++++
 tb/tb_inst_queue.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants and types for the instruction queue between fetch and decode.
package inst_queue_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int INST_WIDTH = 32;
   localparam int PC_WIDTH   = 32;

   // One buffered fetch result; pc sits in the upper half of the stored word.
   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [INST_WIDTH-1:0] inst;
   } iq_entry_t;

endpackage : inst_queue_pkg

// File: rtl/inst_queue.sv
// Instruction queue: circular FIFO of (instruction, pc) pairs from fetch,
// released one per cycle to the decoder while RS and ROB are both ready,
// and flushed completely on a ROB exception.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int POINTER_LENGTH = 3,
   parameter int FULL_MARGIN    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  is_valid_from_if,
   input  logic [INST_WIDTH-1:0] inst_from_if,
   input  logic [PC_WIDTH-1:0]   pc_from_if,
   output logic                  is_full_to_if,
   input  logic                  is_ready_from_rs,
   input  logic                  is_ready_from_rob,
   input  logic                  is_exception_from_rob,
   output logic [INST_WIDTH-1:0] inst_to_dc,
   output logic [PC_WIDTH-1:0]   pc_to_dc,
   output logic                  is_empty_to_dc,
   output logic                  overflow_err
);

   localparam int PTR_W = POINTER_LENGTH + 1;
   localparam int CNT_W = POINTER_LENGTH + 2;

   localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH - FULL_MARGIN);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   iq_entry_t mem [DEPTH];

   logic push;
   logic pop;
   logic drop;

   // Decide this cycle's push / pop / drop; a flush suppresses all three.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      push = FALSE;
      pop  = FALSE;
      drop = FALSE;
      if (!is_exception_from_rob) begin
         // Full detection looks only at count, never at the ready inputs.
         push = is_valid_from_if && (count < DEPTH_CNT);
         drop = is_valid_from_if && (count == DEPTH_CNT);
         pop  = (count != '0) && is_ready_from_rs && is_ready_from_rob;
      end
   end

   // Tell fetch to stop while FULL_MARGIN slots are still free, covering its in-flight requests.
   assign is_full_to_if = (count >= FULL_LEVEL);

   // Head/tail pointers and occupancy count; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (is_exception_from_rob) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_ONE;
         if (pop)  head <= head + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Entry storage written at tail on an accepted push.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; count/pointers alone define which entries are live.
      if (push) mem[tail] <= '{pc: pc_from_if, inst: inst_from_if};
   end

   // Registered decoder interface: load the head entry on a pop, otherwise hold data and flag empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_to_dc     <= '0;
         pc_to_dc       <= '0;
         is_empty_to_dc <= TRUE;
      end else if (pop) begin
         inst_to_dc     <= mem[head].inst;
         pc_to_dc       <= mem[head].pc;
         is_empty_to_dc <= FALSE;
      end else begin
         is_empty_to_dc <= TRUE;
      end
   end

   // Sticky record that fetch pushed into a full queue; survives flushes, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err <= FALSE;
      end else if (drop) begin
         overflow_err <= TRUE;
      end
   end

endmodule : inst_queue

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: table-driven basic order plus
// scoreboard-checked sequences for backpressure, wrap, flush and reset.
module tb_inst_queue;

   logic        clk;
   logic        rst;
   logic        is_valid_from_if;
   logic [31:0] inst_from_if;
   logic [31:0] pc_from_if;
   logic        is_full_to_if;
   logic        is_ready_from_rs;
   logic        is_ready_from_rob;
   logic        is_exception_from_rob;
   logic [31:0] inst_to_dc;
   logic [31:0] pc_to_dc;
   logic        is_empty_to_dc;
   logic        overflow_err;

   inst_queue #(
      .DEPTH(16),
      .POINTER_LENGTH(3),
      .FULL_MARGIN(3)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .is_valid_from_if      (is_valid_from_if),
      .inst_from_if          (inst_from_if),
      .pc_from_if            (pc_from_if),
      .is_full_to_if         (is_full_to_if),
      .is_ready_from_rs      (is_ready_from_rs),
      .is_ready_from_rob     (is_ready_from_rob),
      .is_exception_from_rob (is_exception_from_rob),
      .inst_to_dc            (inst_to_dc),
      .pc_to_dc              (pc_to_dc),
      .is_empty_to_dc        (is_empty_to_dc),
      .overflow_err          (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic        rs;
      logic        rob;
      logic        exp_empty;
      logic [31:0] exp_pc;
   } vec_t;

   ent_t        mq[$];
   logic        exp_ovf;
   logic [31:0] last_pc;
   logic [31:0] last_inst;
   int          delivered;
   int          check_cnt;
   int          err_cnt;

   function automatic logic [31:0] mk_inst(input logic [31:0] p);
      return {16'hC0DE, p[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_cnt++;
      if (actual !== expected) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // One clock cycle: drive inputs at posedge+1, update the model, check outputs at the next posedge+1.
   task automatic step(input logic v, input logic [31:0] p, input logic rs, input logic rob, input logic exc);
      logic exp_pop;
      ent_t popped;
      int   sz;
      is_valid_from_if      = v;
      pc_from_if            = p;
      inst_from_if          = mk_inst(p);
      is_ready_from_rs      = rs;
      is_ready_from_rob     = rob;
      is_exception_from_rob = exc;
      #4;
      sz = mq.size();
      check("is_full_to_if", 32'(is_full_to_if), 32'(sz >= 13));
      exp_pop = 1'b0;
      popped  = '{pc: 32'h0, inst: 32'h0};
      if (exc) begin
         mq.delete();
      end else begin
         if (v && sz == 16) exp_ovf = 1'b1;
         if (sz > 0 && rs && rob) begin
            exp_pop = 1'b1;
            popped  = mq.pop_front();
         end
         if (v && sz < 16) mq.push_back('{pc: p, inst: mk_inst(p)});
      end
      @(posedge clk);
      #1;
      check("is_empty_to_dc", 32'(is_empty_to_dc), 32'(!exp_pop));
      if (exp_pop) begin
         last_pc   = popped.pc;
         last_inst = popped.inst;
         delivered++;
      end
      check("pc_to_dc", pc_to_dc, last_pc);
      check("inst_to_dc", inst_to_dc, last_inst);
      check("overflow_err", 32'(overflow_err), 32'(exp_ovf));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " pc_to_dc"}, pc_to_dc, 32'h0);
      check({tag, " inst_to_dc"}, inst_to_dc, 32'h0);
      check({tag, " is_empty_to_dc"}, 32'(is_empty_to_dc), 32'h1);
      check({tag, " overflow_err"}, 32'(overflow_err), 32'h0);
      check({tag, " is_full_to_if"}, 32'(is_full_to_if), 32'h0);
   endtask

   vec_t vecs[5];

   initial begin
      int pushed;
      int start_delivered;
      logic [31:0] next_pc;

      check_cnt = 0;
      err_cnt   = 0;
      exp_ovf   = 1'b0;
      last_pc   = 32'h0;
      last_inst = 32'h0;
      delivered = 0;

      rst                   = 1'b1;
      is_valid_from_if      = 1'b0;
      inst_from_if          = 32'h0;
      pc_from_if            = 32'h0;
      is_ready_from_rs      = 1'b0;
      is_ready_from_rob     = 1'b0;
      is_exception_from_rob = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic order: first delivery two edges after its push, then back to back, then empty.
      vecs[0] = '{valid: 1'b1, pc: 32'h0, rs: 1'b1, rob: 1'b1, exp_empty: 1'b1, exp_pc: 32'h0};
      vecs[1] = '{valid: 1'b1, pc: 32'h4, rs: 1'b1, rob: 1'b1, exp_empty: 1'b0, exp_pc: 32'h0};
      vecs[2] = '{valid: 1'b1, pc: 32'h8, rs: 1'b1, rob: 1'b1, exp_empty: 1'b0, exp_pc: 32'h4};
      vecs[3] = '{valid: 1'b0, pc: 32'h0, rs: 1'b1, rob: 1'b1, exp_empty: 1'b0, exp_pc: 32'h8};
      vecs[4] = '{valid: 1'b0, pc: 32'h0, rs: 1'b1, rob: 1'b1, exp_empty: 1'b1, exp_pc: 32'h8};
      for (int i = 0; i < 5; i++) begin
         step(vecs[i].valid, vecs[i].pc, vecs[i].rs, vecs[i].rob, 1'b0);
         check("vec empty", 32'(is_empty_to_dc), 32'(vecs[i].exp_empty));
         check("vec pc", pc_to_dc, vecs[i].exp_pc);
      end

      // Simultaneous push and pop at count 1: the older entry comes out, occupancy stays 1.
      step(1'b1, 32'h400, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h404, 1'b1, 1'b1, 1'b0);
      check("pushpop older pc", pc_to_dc, 32'h400);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("pushpop second pc", pc_to_dc, 32'h404);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("pushpop drained", 32'(is_empty_to_dc), 32'h1);

      // Backpressure: fill to 16 with RS stalled, overflow a 17th, then drain in order.
      for (int i = 0; i < 13; i++) step(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b1, 1'b0);
      check("full at 13", 32'(is_full_to_if), 32'h1);
      for (int i = 13; i < 16; i++) step(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b1, 1'b0);
      check("no overflow at 16", 32'(overflow_err), 32'h0);
      step(1'b1, 32'hDEAD_0000, 1'b0, 1'b1, 1'b0);
      check("overflow set", 32'(overflow_err), 32'h1);
      start_delivered = delivered;
      for (int i = 0; i < 17; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("drained 16", 32'(delivered - start_delivered), 32'd16);
      check("last drained pc", pc_to_dc, 32'h103C);

      // Wrap-around with random readiness: 40 accepted pushes, strict FIFO order.
      pushed = 0;
      next_pc = 32'h2000;
      start_delivered = delivered;
      for (int cyc = 0; cyc < 400 && pushed < 40; cyc++) begin
         logic v;
         v = ($urandom_range(0, 3) != 0);
         if (v && mq.size() < 16) begin
            step(1'b1, next_pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            next_pc = next_pc + 32'h4;
            pushed++;
         end else begin
            step(1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
         end
      end
      check("wrap pushes done", 32'(pushed), 32'd40);
      for (int cyc = 0; cyc < 40 && mq.size() > 0; cyc++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("wrap delivered", 32'(delivered - start_delivered), 32'd40);
      check("wrap last pc", pc_to_dc, 32'h2000 + 32'd39 * 32'h4);

      // Flush with a concurrent push and ready: nothing delivered, later push is next out.
      for (int i = 0; i < 5; i++) step(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
      check("flush empty", 32'(is_empty_to_dc), 32'h1);
      check("flush keeps overflow", 32'(overflow_err), 32'h1);
      step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
      check("post-flush empty", 32'(is_empty_to_dc), 32'h1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("post-flush pc", pc_to_dc, 32'h200);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

      // Async reset between edges with 7 entries queued and a live output.
      for (int i = 0; i < 8; i++) step(1'b1, 32'h5000 + 32'(i * 4), 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("pre-reset pc", pc_to_dc, 32'h5000);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async reset");
      mq.delete();
      exp_ovf   = 1'b0;
      last_pc   = 32'h0;
      last_inst = 32'h0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("after reset no delivery", 32'(is_empty_to_dc), 32'h1);
      step(1'b1, 32'h600, 1'b1, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("after reset first pc", pc_to_dc, 32'h600);

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule : tb_inst_queue
